// File: rtl/pw_pattern_match.sv
// Masked byte-stream pattern matcher: compares the last N accepted bytes of the
// current packet against a programmable pattern and fires a one-shot match pulse.
module pw_pattern_match #(
    parameter int pPATTERN_BYTES  = 64,
    parameter int pBYTECOUNT_SIZE = 7
) (
    input  logic                            fe_clk,
    input  logic                            reset_i,
    input  logic [7:0]                      I_fe_data,
    input  logic                            I_fe_data_valid,
    input  logic                            I_rx_active,
    input  logic [8*pPATTERN_BYTES-1:0]     I_pattern,
    input  logic [8*pPATTERN_BYTES-1:0]     I_mask,
    input  logic [pBYTECOUNT_SIZE-1:0]      I_bytes_to_match,
    input  logic                            I_arm,
    input  logic                            I_disarm,
    output logic                            O_armed,
    output logic                            O_match,
    output logic                            O_matched
);

    localparam int FW = $clog2(pPATTERN_BYTES + 1);
    localparam int IW = $clog2(pPATTERN_BYTES);

    typedef enum logic {
        S_DISARMED = 1'b0,
        S_ARMED    = 1'b1
    } state_t;

    state_t                               state_q;
    logic                                 match_q;
    logic                                 matched_q;
    logic [pPATTERN_BYTES-1:0][7:0]       hist_q, hist_d, win;
    logic [FW-1:0]                        fill_q, fill_d, fill_base, fill_new, n_eff;
    logic                                 rx_active_q;
    logic                                 stale_q, stale_d;
    logic                                 rx_rise, accept, counted, mismatch, hit;
    logic [IW-1:0]                        idx;

    // stale_q blocks counting after reset until a fresh packet starts, so a
    // packet interrupted by reset can never complete a match.
    always_comb begin
        rx_rise   = I_rx_active & ~rx_active_q;
        accept    = I_fe_data_valid & I_rx_active;
        stale_d   = stale_q & ~rx_rise;
        counted   = accept & ~stale_d;
        fill_base = rx_rise ? '0 : fill_q;
        fill_new  = (fill_base == FW'(pPATTERN_BYTES)) ? fill_base : fill_base + FW'(1);

        if (int'(I_bytes_to_match) > pPATTERN_BYTES)
            n_eff = FW'(pPATTERN_BYTES);
        else
            n_eff = FW'(I_bytes_to_match);

        win    = {hist_q[pPATTERN_BYTES-2:0], I_fe_data};
        hist_d = accept ? win : hist_q;

        fill_d = fill_base;
        if (counted)
            fill_d = fill_new;

        // Pattern byte i lines up with window entry n_eff-1-i (pattern byte 0 oldest).
        mismatch = 1'b0;
        idx      = '0;
        for (int i = 0; i < pPATTERN_BYTES; i++) begin
            if (i < int'(n_eff)) begin
                idx = IW'(int'(n_eff) - 1 - i);
                if (((win[idx] ^ I_pattern[8*i +: 8]) & I_mask[8*i +: 8]) != 8'h00)
                    mismatch = 1'b1;
            end
        end

        hit = counted && (n_eff != '0) && (fill_new >= n_eff) && !mismatch;
    end

    always_ff @(posedge fe_clk or posedge reset_i) begin
        if (reset_i) begin
            hist_q      <= '0;
            fill_q      <= '0;
            rx_active_q <= 1'b1;
            stale_q     <= 1'b1;
        end else begin
            hist_q      <= hist_d;
            fill_q      <= fill_d;
            rx_active_q <= I_rx_active;
            stale_q     <= stale_d;
        end
    end

    always_ff @(posedge fe_clk or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= S_DISARMED;
            match_q   <= 1'b0;
            matched_q <= 1'b0;
        end else begin
            match_q <= 1'b0;
            case (state_q)
                S_DISARMED: begin
                    if (I_arm && !I_disarm) begin
                        state_q   <= S_ARMED;
                        matched_q <= 1'b0;
                    end
                end
                S_ARMED: begin
                    if (I_disarm) begin
                        state_q <= S_DISARMED;
                    end else if (hit) begin
                        state_q   <= S_DISARMED;
                        match_q   <= 1'b1;
                        matched_q <= 1'b1;
                    end
                end
                default: state_q <= S_DISARMED;
            endcase
        end
    end

    assign O_armed   = (state_q == S_ARMED);
    assign O_match   = match_q;
    assign O_matched = matched_q;

endmodule

// File: tb/tb_pw_pattern_match.sv
// Scoreboard bench for pw_pattern_match: a packet-level reference model predicts
// per-cycle status and match pulses; a monitor compares them against the DUT.
module tb_pw_pattern_match;

    localparam int P = 64;

    logic             fe_clk = 1'b0;
    logic             reset_i = 1'b1;
    logic [7:0]       I_fe_data = 8'h00;
    logic             I_fe_data_valid = 1'b0;
    logic             I_rx_active = 1'b0;
    logic [8*P-1:0]   I_pattern = '0;
    logic [8*P-1:0]   I_mask = '0;
    logic [6:0]       I_bytes_to_match = '0;
    logic             I_arm = 1'b0;
    logic             I_disarm = 1'b0;
    logic             O_armed, O_match, O_matched;

    pw_pattern_match #(.pPATTERN_BYTES(P), .pBYTECOUNT_SIZE(7)) dut (
        .fe_clk           (fe_clk),
        .reset_i          (reset_i),
        .I_fe_data        (I_fe_data),
        .I_fe_data_valid  (I_fe_data_valid),
        .I_rx_active      (I_rx_active),
        .I_pattern        (I_pattern),
        .I_mask           (I_mask),
        .I_bytes_to_match (I_bytes_to_match),
        .I_arm            (I_arm),
        .I_disarm         (I_disarm),
        .O_armed          (O_armed),
        .O_match          (O_match),
        .O_matched        (O_matched)
    );

    always #5 fe_clk = ~fe_clk;

    typedef struct packed {
        int   idx;
        logic armed;
        logic match;
        logic matched;
    } exp_t;

    exp_t        stat_q[$];
    int          ev_q[$];
    int          checks = 0;
    int          errors = 0;
    int          drv_idx = 0;

    // reference model: the current packet's bytes plus the arm state
    bit          m_armed = 0, m_matched = 0, m_prev = 1, m_stale = 1;
    logic [7:0]  pkt[$];
    logic [7:0]  cfg_pat[P];
    logic [7:0]  cfg_msk[P];
    int          cfg_n = 0;
    logic [7:0]  tx[$];

    function automatic bit model_hit();
        int neff;
        neff = (cfg_n > P) ? P : cfg_n;
        if (neff == 0 || pkt.size() < neff) return 1'b0;
        for (int i = 0; i < neff; i++)
            if (((pkt[pkt.size() - neff + i] ^ cfg_pat[i]) & cfg_msk[i]) != 8'h00) return 1'b0;
        return 1'b1;
    endfunction

    task automatic clear_cfg();
        for (int i = 0; i < P; i++) begin
            cfg_pat[i] = 8'h00;
            cfg_msk[i] = 8'h00;
        end
    endtask

    task automatic apply_cfg(input int n);
        for (int i = 0; i < P; i++) begin
            I_pattern[8*i +: 8] = cfg_pat[i];
            I_mask[8*i +: 8]    = cfg_msk[i];
        end
        cfg_n            = n;
        I_bytes_to_match = 7'(n);
    endtask

    task automatic step(input bit v, input logic [7:0] d, input bit rxa,
                        input bit arm = 1'b0, input bit dis = 1'b0);
        exp_t e;
        bit   hit;
        I_fe_data_valid = v;
        I_fe_data       = d;
        I_rx_active     = rxa;
        I_arm           = arm;
        I_disarm        = dis;
        hit = 1'b0;
        if (rxa && !m_prev) begin
            pkt.delete();
            m_stale = 1'b0;
        end
        if (v && rxa && !m_stale) begin
            pkt.push_back(d);
            if (pkt.size() > P) void'(pkt.pop_front());
            hit = model_hit();
        end
        m_prev  = rxa;
        e.match = 1'b0;
        if (!m_armed) begin
            if (arm && !dis) begin
                m_armed   = 1'b1;
                m_matched = 1'b0;
            end
        end else if (dis) begin
            m_armed = 1'b0;
        end else if (hit) begin
            m_armed   = 1'b0;
            m_matched = 1'b1;
            e.match   = 1'b1;
            ev_q.push_back(drv_idx);
        end
        e.idx     = drv_idx;
        e.armed   = m_armed;
        e.matched = m_matched;
        stat_q.push_back(e);
        drv_idx++;
        @(posedge fe_clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic send();
        foreach (tx[i]) step(1'b1, tx[i], 1'b1);
        step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic send2(input logic [7:0] a, input logic [7:0] b);
        tx.delete();
        tx.push_back(a);
        tx.push_back(b);
        send();
    endtask

    task automatic arm();
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic disarm();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    // Monitor: status is checked every cycle; a pulse must pop a predicted event.
    always @(posedge fe_clk or posedge reset_i) begin
        exp_t s;
        int   ev;
        #2;
        if (reset_i) begin
            stat_q.delete();
            ev_q.delete();
            checks++;
            if ({O_armed, O_match, O_matched} != 3'b000) begin
                errors++;
                $display("FAIL reset_outputs: armed/match/matched got %b%b%b want 000",
                         O_armed, O_match, O_matched);
            end
        end else if (stat_q.size() > 0) begin
            s = stat_q.pop_front();
            checks++;
            if (O_armed !== s.armed) begin
                errors++;
                $display("FAIL armed step %0d: got %b want %b", s.idx, O_armed, s.armed);
            end
            checks++;
            if (O_matched !== s.matched) begin
                errors++;
                $display("FAIL matched step %0d: got %b want %b", s.idx, O_matched, s.matched);
            end
            checks++;
            if (O_match !== s.match) begin
                errors++;
                $display("FAIL match step %0d: got %b want %b", s.idx, O_match, s.match);
            end
            if (O_match === 1'b1) begin
                checks++;
                if (ev_q.size() == 0) begin
                    errors++;
                    $display("FAIL pulse_event step %0d: got pulse want none", s.idx);
                end else begin
                    ev = ev_q.pop_front();
                    if (ev != s.idx) begin
                        errors++;
                        $display("FAIL pulse_event: got step %0d want step %0d", s.idx, ev);
                    end
                end
            end
        end
    end

    initial begin
        bit rx;
        clear_cfg();
        apply_cfg(0);
        @(posedge fe_clk);
        @(negedge fe_clk);
        reset_i = 1'b0;
        #1;
        idle(2);

        // basic three-byte match
        clear_cfg();
        cfg_pat[0] = 8'h2D; cfg_pat[1] = 8'h00; cfg_pat[2] = 8'h10;
        cfg_msk[0] = 8'hFF; cfg_msk[1] = 8'hFF; cfg_msk[2] = 8'hFF;
        apply_cfg(3);
        arm();
        idle(1);
        tx.delete();
        tx.push_back(8'hA5); tx.push_back(8'h2D); tx.push_back(8'h00); tx.push_back(8'h10);
        send();
        idle(2);

        // masked byte and don't-care byte
        clear_cfg();
        cfg_pat[0] = 8'hC3; cfg_msk[0] = 8'hFF;
        apply_cfg(2);
        arm();
        send2(8'hC3, 8'h7E);
        arm();
        send2(8'hC2, 8'h7E);
        idle(1);
        disarm();

        // packet boundary
        clear_cfg();
        cfg_pat[0] = 8'h11; cfg_pat[1] = 8'h22;
        cfg_msk[0] = 8'hFF; cfg_msk[1] = 8'hFF;
        apply_cfg(2);
        arm();
        send2(8'h33, 8'h11);
        send2(8'h22, 8'h44);
        send2(8'h11, 8'h22);

        // one-shot then re-arm
        arm();
        tx.delete();
        tx.push_back(8'h11); tx.push_back(8'h22); tx.push_back(8'h11); tx.push_back(8'h22);
        send();
        arm();
        send2(8'h11, 8'h22);

        // arm and disarm together, disarm on completing byte, hit on arm cycle
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        arm();
        step(1'b1, 8'h11, 1'b1);
        step(1'b1, 8'h22, 1'b1, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h11, 1'b1);
        step(1'b1, 8'h22, 1'b1, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        disarm();

        // N = 0 never matches
        apply_cfg(0);
        arm();
        send2(8'h11, 8'h22);
        disarm();

        // window shorter than N
        clear_cfg();
        cfg_pat[1] = 8'h22; cfg_msk[1] = 8'hFF;
        apply_cfg(2);
        arm();
        tx.delete();
        tx.push_back(8'h22);
        send();
        send2(8'h55, 8'h22);

        // reset mid-packet while armed, then stale bytes must not match
        clear_cfg();
        cfg_pat[0] = 8'h11; cfg_pat[1] = 8'h22;
        cfg_msk[0] = 8'hFF; cfg_msk[1] = 8'hFF;
        apply_cfg(2);
        arm();
        step(1'b1, 8'h11, 1'b1);
        #2;
        reset_i   = 1'b1;
        m_armed   = 1'b0;
        m_matched = 1'b0;
        m_prev    = 1'b1;
        m_stale   = 1'b1;
        pkt.delete();
        @(posedge fe_clk);
        @(negedge fe_clk);
        reset_i = 1'b0;
        #1;
        step(1'b1, 8'h11, 1'b1);
        step(1'b1, 8'h22, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        step(1'b1, 8'h11, 1'b1);
        step(1'b1, 8'h22, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        send2(8'h11, 8'h22);

        // full-depth window, and N above depth clamps to depth
        for (int rep = 0; rep < 2; rep++) begin
            clear_cfg();
            for (int i = 0; i < P; i++) begin
                cfg_pat[i] = 8'($urandom);
                cfg_msk[i] = 8'hFF;
            end
            apply_cfg(rep == 0 ? P : 100);
            arm();
            tx.delete();
            for (int i = 0; i < 10; i++) tx.push_back(8'($urandom));
            for (int i = 0; i < P; i++) tx.push_back(cfg_pat[i]);
            send();
        end

        // randomized traffic over a small alphabet
        rx = 1'b0;
        for (int blk = 0; blk < 20; blk++) begin
            disarm();
            clear_cfg();
            for (int i = 0; i < 4; i++) begin
                cfg_pat[i] = 8'($urandom_range(0, 3));
                case ($urandom_range(0, 3))
                    0: cfg_msk[i] = 8'hFF;
                    1: cfg_msk[i] = 8'h03;
                    2: cfg_msk[i] = 8'h01;
                    default: cfg_msk[i] = 8'h00;
                endcase
            end
            apply_cfg($urandom_range(0, 4));
            for (int c = 0; c < 40; c++) begin
                if ($urandom_range(0, 9) == 0) rx = ~rx;
                step(($urandom_range(0, 3) != 0), 8'($urandom_range(0, 3)), rx,
                     ($urandom_range(0, 7) == 0), ($urandom_range(0, 31) == 0));
            end
        end

        idle(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
